framebuffer_rect_filler: RTL and testbench

// - Command-driven rectangle fill engine; the writer side of the display framebuffer write port.
// - Accepts one rectangle command (origin, size, colour) per handshake.
// - Emits one framebuffer write per clock, row-major, clipped to the 128x96 visible area.
// - write/writeAddress/writeData connect directly to the display's framebuffer write inputs.
// - writeAddress format is {y[6:0], x[6:0]}.

---
 rtl/framebuffer_rect_filler_if.sv | 37 +++
 rtl/framebuffer_rect_filler.sv | 159 +++++++++++++++
 tb/tb_framebuffer_rect_filler.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/framebuffer_rect_filler_if.sv
// Command and framebuffer-write bundle for the rectangle fill engine.
// cmdChecker exists only when RECT_FILL_CHECKER_EN is defined.
interface framebuffer_rect_filler_if;
  logic        cmdValid;
  logic        cmdReady;
  logic [6:0]  cmdX0;
  logic [6:0]  cmdY0;
  logic [7:0]  cmdWidth;
  logic [7:0]  cmdHeight;
  logic [2:0]  cmdColor;
`ifdef RECT_FILL_CHECKER_EN
  logic        cmdChecker;
`endif
  logic        write;
  logic [13:0] writeAddress;
  logic [2:0]  writeData;
  logic        busy;
  logic        done;

  // Command issuer side.
  modport master (
`ifdef RECT_FILL_CHECKER_EN
    output cmdChecker,
`endif
    output cmdValid, cmdX0, cmdY0, cmdWidth, cmdHeight, cmdColor,
    input  cmdReady, write, writeAddress, writeData, busy, done
  );

  // Fill engine side.
  modport slave (
`ifdef RECT_FILL_CHECKER_EN
    input  cmdChecker,
`endif
    input  cmdValid, cmdX0, cmdY0, cmdWidth, cmdHeight, cmdColor,
    output cmdReady, write, writeAddress, writeData, busy, done
  );
endinterface

// File: rtl/framebuffer_rect_filler.sv
// Rectangle fill engine: one clipped, row-major framebuffer write per clock.
// Define RECT_FILL_CHECKER_EN to add a per-command checkerboard pattern option.
module framebuffer_rect_filler #(
  parameter int SCREEN_W = 128,
  parameter int SCREEN_H = 96
) (
  input logic clk,
  input logic reset,
  framebuffer_rect_filler_if.slave fb
);
  // state | meaning
  // IDLE  | no fill active; cmdReady high, commands accepted here
  // FILL  | one framebuffer write presented every cycle

  typedef enum logic {S_IDLE, S_FILL} state_t;

  localparam logic [8:0] W_LIM = 9'(SCREEN_W);
  localparam logic [8:0] H_LIM = 9'(SCREEN_H);

  state_t      state, state_n;
  logic [6:0]  x_cur, x_cur_n;
  logic [6:0]  y_cur, y_cur_n;
  logic [6:0]  x0_q, x0_n;
  logic [8:0]  x_end_q, x_end_n;
  logic [8:0]  y_end_q, y_end_n;
  logic [2:0]  color_q, color_n;
`ifdef RECT_FILL_CHECKER_EN
  logic        checker_q, checker_n;
`endif

  logic        write_q, write_n;
  logic        done_q, done_n;
  logic        busy_q, busy_n;
  logic [13:0] addr_q, addr_n;
  logic [2:0]  data_q, data_n;
  logic [2:0]  pix;

  logic        accept;
  logic        cmd_empty;
  logic [8:0]  x_sum, y_sum;
  logic [8:0]  x_clip, y_clip;
  logic        x_more, y_more;

  // Clip bounds are exclusive ends computed with 9-bit sums so nothing wraps.
  assign accept    = fb.cmdValid & ~busy_q;
  assign x_sum     = {2'b00, fb.cmdX0} + {1'b0, fb.cmdWidth};
  assign y_sum     = {2'b00, fb.cmdY0} + {1'b0, fb.cmdHeight};
  assign x_clip    = (x_sum > W_LIM) ? W_LIM : x_sum;
  assign y_clip    = (y_sum > H_LIM) ? H_LIM : y_sum;
  assign cmd_empty = (fb.cmdWidth == 8'd0) | (fb.cmdHeight == 8'd0) |
                     ({2'b00, fb.cmdY0} >= H_LIM);
  assign x_more    = ({2'b00, x_cur} + 9'd1) < x_end_q;
  assign y_more    = ({2'b00, y_cur} + 9'd1) < y_end_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      x_cur     <= '0;
      y_cur     <= '0;
      x0_q      <= '0;
      x_end_q   <= '0;
      y_end_q   <= '0;
      color_q   <= '0;
`ifdef RECT_FILL_CHECKER_EN
      checker_q <= 1'b0;
`endif
      write_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state     <= state_n;
      x_cur     <= x_cur_n;
      y_cur     <= y_cur_n;
      x0_q      <= x0_n;
      x_end_q   <= x_end_n;
      y_end_q   <= y_end_n;
      color_q   <= color_n;
`ifdef RECT_FILL_CHECKER_EN
      checker_q <= checker_n;
`endif
      write_q   <= write_n;
      done_q    <= done_n;
      busy_q    <= busy_n;
      addr_q    <= addr_n;
      data_q    <= data_n;
    end
  end

  always_comb begin
    state_n   = state;
    x_cur_n   = x_cur;
    y_cur_n   = y_cur;
    x0_n      = x0_q;
    x_end_n   = x_end_q;
    y_end_n   = y_end_q;
    color_n   = color_q;
`ifdef RECT_FILL_CHECKER_EN
    checker_n = checker_q;
`endif
    write_n   = 1'b0;
    done_n    = 1'b0;

    case (state)
      S_IDLE: begin
        if (accept) begin
          x0_n      = fb.cmdX0;
          x_end_n   = x_clip;
          y_end_n   = y_clip;
          color_n   = fb.cmdColor;
`ifdef RECT_FILL_CHECKER_EN
          checker_n = fb.cmdChecker;
`endif
          if (cmd_empty) begin
            done_n = 1'b1;
          end else begin
            state_n = S_FILL;
            write_n = 1'b1;
            x_cur_n = fb.cmdX0;
            y_cur_n = fb.cmdY0;
          end
        end
      end
      S_FILL: begin
        if (x_more) begin
          x_cur_n = x_cur + 7'd1;
          write_n = 1'b1;
        end else if (y_more) begin
          x_cur_n = x0_q;
          y_cur_n = y_cur + 7'd1;
          write_n = 1'b1;
        end else begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

`ifdef RECT_FILL_CHECKER_EN
    pix = (checker_n && (x_cur_n[0] ^ y_cur_n[0])) ? ~color_n : color_n;
`else
    pix = color_n;
`endif

    // Address and data hold their last value between fills.
    busy_n = (state_n == S_FILL);
    addr_n = write_n ? {y_cur_n, x_cur_n} : addr_q;
    data_n = write_n ? pix : data_q;
  end

  assign fb.cmdReady     = ~busy_q;
  assign fb.write        = write_q;
  assign fb.writeAddress = addr_q;
  assign fb.writeData    = data_q;
  assign fb.busy         = busy_q;
  assign fb.done         = done_q;
endmodule

// File: tb/tb_framebuffer_rect_filler.sv
// Scoreboard bench for framebuffer_rect_filler: driver pushes expected writes/done
// pulses with their cycle, a negedge monitor pops and compares.
module tb_framebuffer_rect_filler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  framebuffer_rect_filler_if fb();
  framebuffer_rect_filler dut (.clk(clk), .reset(reset), .fb(fb));

  typedef struct {
    bit          is_done;
    int          cyc;
    logic [13:0] addr;
    logic [2:0]  data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   acc, acc_a, acc_b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_wr(input int c, input logic [13:0] a, input logic [2:0] d);
    exp_t e;
    e.is_done = 1'b0; e.cyc = c; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  task automatic push_done(input int c);
    exp_t e;
    e.is_done = 1'b1; e.cyc = c; e.addr = '0; e.data = '0;
    sb.push_back(e);
  endtask

  // Offers a command at a negedge; returns the cycle in which its first output is due.
  task automatic send_cmd(input logic [6:0] x0, input logic [6:0] y0,
                          input logic [7:0] w, input logic [7:0] h,
                          input logic [2:0] c, input bit chk, input bit hold,
                          output int acc_cyc);
    acc_cyc = -1;
    fb.cmdX0 = x0; fb.cmdY0 = y0; fb.cmdWidth = w; fb.cmdHeight = h; fb.cmdColor = c;
`ifdef RECT_FILL_CHECKER_EN
    fb.cmdChecker = chk;
`else
    if (chk) $display("note: checker pattern not built in, solid fill used");
`endif
    fb.cmdValid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (fb.cmdReady === 1'b1) begin
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc_cyc < 0) begin
      total++; bad++;
      $display("FAIL accept_timeout: got no accept in 300 cycles want accept");
    end
    if (!hold) fb.cmdValid = 1'b0;
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending events want 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_en && !reset) begin
        if (fb.write === 1'b1) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got addr %h at cycle %0d want none", fb.writeAddress, cyc);
          end else begin
            mon_e = sb.pop_front();
            if (mon_e.is_done || mon_e.cyc != cyc || mon_e.addr !== fb.writeAddress || mon_e.data !== fb.writeData) begin
              bad++;
              $display("FAIL write: got addr %h data %0d cycle %0d want done=%0d addr %h data %0d cycle %0d",
                       fb.writeAddress, fb.writeData, cyc, mon_e.is_done, mon_e.addr, mon_e.data, mon_e.cyc);
            end
          end
          check("busy_during_fill", fb.busy, 1);
          check("ready_during_fill", fb.cmdReady, 0);
        end
        if (fb.done === 1'b1) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_done: got done at cycle %0d want none", cyc);
          end else begin
            mon_e = sb.pop_front();
            if (!mon_e.is_done || mon_e.cyc != cyc) begin
              bad++;
              $display("FAIL done: got done at cycle %0d want done=%0d at cycle %0d",
                       cyc, mon_e.is_done, mon_e.cyc);
            end
          end
          check("busy_at_done", fb.busy, 0);
          check("ready_at_done", fb.cmdReady, 1);
        end
        if (fb.write !== 1'b1 && fb.done !== 1'b1 && sb.size() > 0 && sb[0].cyc < cyc) begin
          total++; bad++;
          mon_e = sb.pop_front();
          $display("FAIL missing_event: got nothing at cycle %0d want done=%0d addr %h due cycle %0d",
                   cyc, mon_e.is_done, mon_e.addr, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    fb.cmdValid = 1'b0; fb.cmdX0 = '0; fb.cmdY0 = '0;
    fb.cmdWidth = '0; fb.cmdHeight = '0; fb.cmdColor = '0;
`ifdef RECT_FILL_CHECKER_EN
    fb.cmdChecker = 1'b0;
`endif
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_write", fb.write, 0);
    check("rst_busy", fb.busy, 0);
    check("rst_done", fb.done, 0);
    check("rst_ready", fb.cmdReady, 1);
    check("rst_addr", fb.writeAddress, 0);
    check("rst_data", fb.writeData, 0);
    mon_en = 1'b1;
    repeat (4) @(negedge clk);

    // Basic 3x2 fill at (2,3)
    send_cmd(7'd2, 7'd3, 8'd3, 8'd2, 3'd5, 1'b0, 1'b0, acc);
    push_wr(acc + 0, 14'h0182, 3'd5);
    push_wr(acc + 1, 14'h0183, 3'd5);
    push_wr(acc + 2, 14'h0184, 3'd5);
    push_wr(acc + 3, 14'h0202, 3'd5);
    push_wr(acc + 4, 14'h0203, 3'd5);
    push_wr(acc + 5, 14'h0204, 3'd5);
    push_done(acc + 6);
    drain(50);

    // Bottom-right clip
    send_cmd(7'd126, 7'd95, 8'd4, 8'd4, 3'd7, 1'b0, 1'b0, acc);
    push_wr(acc + 0, 14'h2FFE, 3'd7);
    push_wr(acc + 1, 14'h2FFF, 3'd7);
    push_done(acc + 2);
    drain(50);

    // Empty commands
    send_cmd(7'd0, 7'd0, 8'd0, 8'd5, 3'd1, 1'b0, 1'b0, acc);
    push_done(acc);
    drain(20);
    send_cmd(7'd10, 7'd10, 8'd5, 8'd0, 3'd2, 1'b0, 1'b0, acc);
    push_done(acc);
    drain(20);
    send_cmd(7'd0, 7'd100, 8'd1, 8'd1, 3'd3, 1'b0, 1'b0, acc);
    push_done(acc);
    check("empty_busy_after", fb.busy, 0);
    drain(20);

    // Back-to-back with cmdValid held high
    send_cmd(7'd0, 7'd0, 8'd1, 8'd1, 3'd4, 1'b0, 1'b1, acc_a);
    push_wr(acc_a, 14'h0000, 3'd4);
    push_done(acc_a + 1);
    send_cmd(7'd5, 7'd5, 8'd2, 8'd1, 3'd6, 1'b0, 1'b0, acc_b);
    check("b2b_accept_cycle", acc_b, acc_a + 2);
    push_wr(acc_b + 0, 14'h0285, 3'd6);
    push_wr(acc_b + 1, 14'h0286, 3'd6);
    push_done(acc_b + 2);
    drain(50);

    // Full-screen fill to completion
    send_cmd(7'd0, 7'd0, 8'd128, 8'd96, 3'd2, 1'b0, 1'b0, acc);
    for (int y = 0; y < 96; y++)
      for (int x = 0; x < 128; x++)
        push_wr(acc + y * 128 + x, {7'(y), 7'(x)}, 3'd2);
    push_done(acc + 12288);
    drain(13000);

    // Full-screen fill aborted by reset after the third write
    send_cmd(7'd0, 7'd0, 8'd128, 8'd96, 3'd4, 1'b0, 1'b0, acc);
    push_wr(acc + 0, 14'h0000, 3'd4);
    push_wr(acc + 1, 14'h0001, 3'd4);
    push_wr(acc + 2, 14'h0002, 3'd4);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    #2;
    check("abort_write", fb.write, 0);
    check("abort_busy", fb.busy, 0);
    check("abort_done", fb.done, 0);
    check("abort_ready", fb.cmdReady, 1);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_pending", sb.size(), 0);
    sb.delete();
    repeat (2) @(negedge clk);

`ifdef RECT_FILL_CHECKER_EN
    // Checkerboard full screen, colour 1 alternates with 6
    send_cmd(7'd0, 7'd0, 8'd128, 8'd96, 3'd1, 1'b1, 1'b0, acc);
    for (int y = 0; y < 96; y++)
      for (int x = 0; x < 128; x++)
        push_wr(acc + y * 128 + x, {7'(y), 7'(x)}, ((x ^ y) & 1) != 0 ? 3'd6 : 3'd1);
    push_done(acc + 12288);
    drain(13000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
